// File: rtl/tag_valid_table.sv
// tag_valid_table: DEPTH-entry tag/valid store with registered hit/miss
// lookups, fills, and a sequential invalidate-all sweep.
//
// Optional build macro TAG_VALID_TABLE_STATS_EN adds saturating 16-bit
// hit/miss counters (hit_cnt_o / miss_cnt_o) driven from lookup results.
//
// DEPTH must be a power of two (>= 2) and IDX_W must equal log2(DEPTH), so
// every index value addresses a real entry.
module tag_valid_table #(
    parameter int TAG_W = 3,
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,

    // lookup request
    input  logic             lk_valid_i,
    input  logic [IDX_W-1:0] lk_idx_i,
    input  logic [TAG_W-1:0] lk_tag_i,

    // fill request
    input  logic             fill_valid_i,
    input  logic [IDX_W-1:0] fill_idx_i,
    input  logic [TAG_W-1:0] fill_tag_i,

    // invalidate-all sweep request
    input  logic             flush_req_i,

    output logic             fill_ready_o,
    output logic             flush_busy_o,
    output logic             res_valid_o,
    output logic             res_hit_o,
    output logic [IDX_W:0]   occupancy_o
`ifdef TAG_VALID_TABLE_STATS_EN
    ,
    output logic [15:0]      hit_cnt_o,
    output logic [15:0]      miss_cnt_o
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [IDX_W-1:0]   ptr_q;

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_d;
    logic [TAG_W-1:0]   tag_q [DEPTH];

    logic [IDX_W:0]     occ_q;
    logic [IDX_W:0]     occ_d;

    logic               res_valid_q;
    logic               res_hit_q;

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    logic               sweeping;
    logic               fill_fire;
    logic               occ_inc;
    logic               occ_dec;
    logic               lk_match;
    logic               res_hit_d;

    assign sweeping  = (state_q == ST_SWEEP);
    assign fill_fire = fill_valid_i && !sweeping;

    // A fill only grows the count when it lands on an invalid entry; the
    // sweep only shrinks it when the entry under the pointer was valid.
    // Fills are blocked during the sweep, so the two never coincide.
    assign occ_inc = fill_fire && !valid_q[fill_idx_i];
    assign occ_dec = sweeping  &&  valid_q[ptr_q];

    // Lookup compares against the pre-edge contents, which gives
    // read-before-write ordering against a same-cycle fill for free.
    assign lk_match  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
    assign res_hit_d = lk_valid_i && !sweeping && lk_match;

    // Next-state of the valid vector: sweep clears the pointed entry,
    // otherwise an accepted fill sets its entry.
    always_comb begin
        valid_d = valid_q;
        for (int e = 0; e < DEPTH; e++) begin
            if (sweeping && (ptr_q == IDX_W'(e))) begin
                valid_d[e] = 1'b0;
            end else if (fill_fire && (fill_idx_i == IDX_W'(e))) begin
                valid_d[e] = 1'b1;
            end
        end
    end

    // Occupancy next-state; inc and dec are mutually exclusive so this
    // never leaves 0..DEPTH.
    always_comb begin
        occ_d = occ_q;
        if (occ_inc) begin
            occ_d = occ_q + (IDX_W+1)'(1);
        end else if (occ_dec) begin
            occ_d = occ_q - (IDX_W+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Sweep FSM: IDLE waits for flush_req, SWEEP walks ptr over every entry
    // once (exactly DEPTH cycles) and ignores further flush requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flush_req_i) begin
                        state_q <= ST_SWEEP;
                        ptr_q   <= '0;
                    end
                end
                ST_SWEEP: begin
                    ptr_q <= ptr_q + IDX_W'(1);
                    if (ptr_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    // Valid bits and occupancy: cleared by reset, otherwise take next-state.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Tag array has no reset; its contents only matter under a valid bit.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            tag_q[fill_idx_i] <= fill_tag_i;
        end
    end

    // Lookup result register: one-cycle latency, hit gated by request.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
        end else begin
            res_valid_q <= lk_valid_i;
            res_hit_q   <= res_hit_d;
        end
    end

`ifdef TAG_VALID_TABLE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Saturating hit/miss counters sampled on each presented result;
    // only reset clears them, a flush leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (res_valid_q) begin
            if (res_hit_q) begin
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_q <= hit_cnt_q + 16'd1;
                end
            end else begin
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign flush_busy_o = sweeping;
    assign fill_ready_o = !sweeping;
    assign res_valid_o  = res_valid_q;
    assign res_hit_o    = res_hit_q;
    assign occupancy_o  = occ_q;

endmodule

// File: tb/tb_tag_valid_table.sv
// Scoreboard bench for tag_valid_table: lookups push their expected hit
// into a queue, a negedge monitor pops and compares each presented result.
module tb_tag_valid_table;

    localparam int TAG_W = 3;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             reset;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             fill_valid;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             flush_req;
    logic             fill_ready;
    logic             flush_busy;
    logic             res_valid;
    logic             res_hit;
    logic [IDX_W:0]   occupancy;
`ifdef TAG_VALID_TABLE_STATS_EN
    logic [15:0]      hit_cnt;
    logic [15:0]      miss_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    bit sb[$];

    tag_valid_table #(.TAG_W(TAG_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .lk_valid_i   (lk_valid),
        .lk_idx_i     (lk_idx),
        .lk_tag_i     (lk_tag),
        .fill_valid_i (fill_valid),
        .fill_idx_i   (fill_idx),
        .fill_tag_i   (fill_tag),
        .flush_req_i  (flush_req),
        .fill_ready_o (fill_ready),
        .flush_busy_o (flush_busy),
        .res_valid_o  (res_valid),
        .res_hit_o    (res_hit),
        .occupancy_o  (occupancy)
`ifdef TAG_VALID_TABLE_STATS_EN
        ,
        .hit_cnt_o    (hit_cnt),
        .miss_cnt_o   (miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue a lookup for this cycle and record the hit it must produce
    task automatic lookup(input int idx, input int tag, input bit exp_hit);
        lk_valid = 1'b1;
        lk_idx   = IDX_W'(idx);
        lk_tag   = TAG_W'(tag);
        sb.push_back(exp_hit);
    endtask

    task automatic fill(input int idx, input int tag);
        fill_valid = 1'b1;
        fill_idx   = IDX_W'(idx);
        fill_tag   = TAG_W'(tag);
    endtask

    task automatic idle_inputs();
        lk_valid   = 1'b0;
        fill_valid = 1'b0;
        flush_req  = 1'b0;
    endtask

    // monitor: every presented result must match the oldest expectation
    always @(negedge clk) begin
        if (mon_en) begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res_unexpected got=res_valid want=no_result");
                end else begin
                    chk("res_hit", int'(res_hit), int'(sb.pop_front()));
                end
            end else begin
                chk("res_hit_idle", int'(res_hit), 0);
            end
        end
    end

    initial begin
        idle_inputs();
        lk_idx   = '0;
        lk_tag   = '0;
        fill_idx = '0;
        fill_tag = '0;
        reset    = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        chk("rst_occ",   int'(occupancy),  0);
        chk("rst_busy",  int'(flush_busy), 0);
        chk("rst_ready", int'(fill_ready), 1);
        chk("rst_resv",  int'(res_valid),  0);

        // lookup on empty table misses
        lookup(5, 3'b010, 1'b0);
        tick();
        idle_inputs();
        chk("empty_occ", int'(occupancy), 0);

        // fill then hit / wrong-tag miss
        fill(2, 3'b101);
        tick();
        idle_inputs();
        chk("fill1_occ", int'(occupancy), 1);
        lookup(2, 3'b101, 1'b1);
        tick();
        lookup(2, 3'b100, 1'b0);
        tick();
        idle_inputs();

        // same-cycle fill + lookup sees the old contents
        fill(4, 3'b011);
        lookup(4, 3'b011, 1'b0);
        tick();
        idle_inputs();
        chk("rbw_occ", int'(occupancy), 2);
        lookup(4, 3'b011, 1'b1);
        tick();
        idle_inputs();

        // fill all entries (2 and 4 already valid), then refill idx 0
        for (int i = 0; i < DEPTH; i++) begin
            fill(i, i);
            tick();
        end
        idle_inputs();
        chk("full_occ", int'(occupancy), 8);
        fill(0, 3'b111);
        tick();
        idle_inputs();
        chk("refill_occ", int'(occupancy), 8);
        lookup(0, 3'b111, 1'b1);
        tick();
        lookup(2, 3'b010, 1'b1);
        tick();
        lookup(2, 3'b101, 1'b0);
        tick();
        idle_inputs();

        // flush with all entries valid
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idle_inputs();
            chk($sformatf("sweep%0d_busy", k),  int'(flush_busy), 1);
            chk($sformatf("sweep%0d_ready", k), int'(fill_ready), 0);
            chk($sformatf("sweep%0d_occ", k),   int'(occupancy),  8 - k);
            if (k == 2) flush_req = 1'b1;
            if (k == 3) fill(1, 3'b110);
            if (k == 5) lookup(6, 3'b110, 1'b0);
            tick();
        end
        idle_inputs();
        chk("post_busy",  int'(flush_busy), 0);
        chk("post_ready", int'(fill_ready), 1);
        chk("post_occ",   int'(occupancy),  0);
        lookup(1, 3'b110, 1'b0);
        tick();
        lookup(6, 3'b110, 1'b0);
        tick();
        idle_inputs();
        tick();
        chk("post_occ2", int'(occupancy), 0);

        // reset in the middle of a sweep
        fill(3, 3'b001);
        tick();
        fill(6, 3'b010);
        tick();
        idle_inputs();
        chk("pre_occ", int'(occupancy), 2);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_busy", int'(flush_busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_busy",  int'(flush_busy), 0);
        chk("rstmid_occ",   int'(occupancy),  0);
        chk("rstmid_ready", int'(fill_ready), 1);
        tick();
        tick();
        chk("rstmid_busy2", int'(flush_busy), 0);
        lookup(6, 3'b010, 1'b0);
        tick();
        idle_inputs();
        tick();

`ifdef TAG_VALID_TABLE_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stat_rst_hit",  int'(hit_cnt),  0);
        chk("stat_rst_miss", int'(miss_cnt), 0);
        fill(0, 3'b001);
        tick();
        fill(1, 3'b010);
        tick();
        idle_inputs();
        lookup(0, 3'b001, 1'b1);
        tick();
        lookup(1, 3'b010, 1'b1);
        tick();
        lookup(0, 3'b001, 1'b1);
        tick();
        lookup(0, 3'b000, 1'b0);
        tick();
        lookup(5, 3'b000, 1'b0);
        tick();
        idle_inputs();
        tick();
        tick();
        chk("stat_hit",  int'(hit_cnt),  3);
        chk("stat_miss", int'(miss_cnt), 2);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) tick();
        chk("stat_flush_hit",  int'(hit_cnt),  3);
        chk("stat_flush_miss", int'(miss_cnt), 2);
`endif

        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tag_valid_table.md
Name: tag_valid_table

Overview:
- Parametrised successor to the single-entry tag/validity compare register.
- Holds DEPTH entries, each with a TAG_W-bit tag and a valid bit.
- Answers registered hit/miss lookups, accepts fills, and supports a sequential flush-all sweep.
- Sits beside the perf_sys cache/predictor tag arrays as the authoritative validity store.

Parameters:
- TAG_W, 3, tag width in bits.
- DEPTH, 8, number of entries; power of two, minimum 2.
- IDX_W, 3, index width; must equal log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- lk_valid  in  1  lookup request this cycle.
- lk_idx  in  IDX_W  lookup entry index.
- lk_tag  in  TAG_W  tag to compare.
- fill_valid  in  1  fill request.
- fill_idx  in  IDX_W  fill entry index.
- fill_tag  in  TAG_W  tag to write; entry becomes valid.
- flush_req  in  1  start invalidate-all sweep (pulse or level).
- fill_ready  out  1  fill accepted this cycle; low while sweeping.
- flush_busy  out  1  sweep in progress.
- res_valid  out  1  lookup result valid (one cycle after lk_valid).
- res_hit  out  1  entry valid and stored tag == lk_tag.
- occupancy  out  IDX_W+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (clk edge with reset=1):
  - all valid bits cleared; tags left don't-care;
  - res_valid=0, res_hit=0, occupancy=0, flush_busy=0;
  - FSM returns to IDLE. This applies mid-sweep too, with no further sweep cycles.
- Lookup:
  - Latency 1. res_valid = registered lk_valid.
  - res_hit = registered (valid[lk_idx] && tag[lk_idx]==lk_tag).
  - res_hit=0 whenever res_valid=0.
- Read-before-write: a lookup and a fill to the same index in the same cycle see the pre-fill contents.
- Fill:
  - When fill_valid && fill_ready: tag[fill_idx]<=fill_tag, valid[fill_idx]<=1.
  - occupancy increments only if the entry was previously invalid. Refilling a valid entry overwrites the tag with occupancy unchanged.
- fill_ready = !flush_busy (combinational from state). Fills offered while not ready are dropped; the producer must hold them.
- FSM states:
  - IDLE: flush_busy=0. On flush_req=1, go to SWEEP with ptr<=0.
  - SWEEP: flush_busy=1. Each cycle valid[ptr]<=0, decrementing occupancy if that entry was valid, then ptr<=ptr+1. When ptr==DEPTH-1, clear that entry and return to IDLE.
  - Sweep duration is exactly DEPTH cycles.
- During SWEEP:
  - lookups still respond with latency 1, but res_hit is forced to 0;
  - flush_req is ignored (no restart);
  - fills are dropped.
- On return to IDLE, occupancy is 0. flush_req asserted on the cycle of return to IDLE starts a new sweep on the next edge.
- Occupancy never wraps. Fill while occupancy==DEPTH is only possible onto a valid entry, so the count stays at DEPTH.
- Index out of range is impossible because DEPTH is a power of two.

Optional Feature:
- Macro TAG_VALID_TABLE_STATS_EN.
- When defined, adds outputs hit_cnt[15:0] and miss_cnt[15:0]:
  - counted on each res_valid cycle (hit or miss respectively);
  - saturate at 16'hFFFF;
  - cleared by reset only, not by flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then lookup idx 5 tag 3'b010 -> next cycle res_valid=1, res_hit=0; occupancy=0.
- Fill idx 2 tag 3'b101, then lookup idx 2 tag 3'b101 -> res_hit=1; lookup with tag 3'b100 -> res_hit=0; occupancy=1.
- Same-cycle fill idx 4 tag 3'b011 and lookup idx 4 tag 3'b011 -> res_hit=0; repeat the lookup one cycle later -> res_hit=1.
- Fill all 8 entries, then refill idx 0 -> occupancy stays 8.
- Flush with 8 valid entries:
  - flush_busy high exactly 8 cycles, fill_ready low for those cycles;
  - fill offered at sweep cycle 3 is dropped;
  - occupancy counts 8 down to 0;
  - lookup during the sweep -> res_hit=0.
- Reset asserted at sweep cycle 4 -> next cycle flush_busy=0 and occupancy=0. With STATS_EN: 3 hits and 2 misses give hit_cnt=3, miss_cnt=2, and both counters hold across a flush.
